// File: rtl/traffic_phase_scheduler_if.sv
// traffic_phase_scheduler_if: bundle between the intersection scheduler and its environment.
// Inputs to the scheduler: tick, sensor, ped_req (night_mode with NIGHT_FLASH_EN).
// Outputs from the scheduler: ped_ack, ped_walk, highway_signal, farm_signal, phase.
// master = environment side, slave = scheduler side.
interface traffic_phase_scheduler_if;
  logic       tick;
  logic       sensor;
  logic       ped_req;
  logic       ped_ack;
  logic       ped_walk;
  logic [1:0] highway_signal;
  logic [1:0] farm_signal;
  logic [2:0] phase;
`ifdef NIGHT_FLASH_EN
  logic       night_mode;

  modport master (
    output tick, sensor, ped_req, night_mode,
    input  ped_ack, ped_walk,
    input  highway_signal, farm_signal, phase
  );

  modport slave (
    input  tick, sensor, ped_req, night_mode,
    output ped_ack, ped_walk,
    output highway_signal, farm_signal, phase
  );
`else
  modport master (
    output tick, sensor, ped_req,
    input  ped_ack, ped_walk,
    input  highway_signal, farm_signal, phase
  );

  modport slave (
    input  tick, sensor, ped_req,
    output ped_ack, ped_walk,
    output highway_signal, farm_signal, phase
  );
`endif
endinterface

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: highway/farm phase sequencer with a pedestrian walk phase.
// Ports: clk, rst (async, active-low), ctl (slave side of traffic_phase_scheduler_if).
// Optional macro NIGHT_FLASH_EN adds night_mode and the flashing state FLASH(7).
// Durations count tick enables; lamps use 00 RED, 01 YELLOW, 10 GREEN, 11 DARK.
module traffic_phase_scheduler #(
  parameter int CNT_W          = 8,
  parameter int HWY_MIN_GREEN  = 20,
  parameter int YELLOW_TIME    = 4,
  parameter int ALL_RED_TIME   = 2,
  parameter int FARM_MIN_GREEN = 10,
  parameter int FARM_MAX_GREEN = 30,
  parameter int PED_WALK       = 8
) (
  input logic clk,
  input logic rst,
  traffic_phase_scheduler_if.slave ctl
);

  localparam logic [2:0] S_HG   = 3'd0;
  localparam logic [2:0] S_HY   = 3'd1;
  localparam logic [2:0] S_AR1  = 3'd2;
  localparam logic [2:0] S_FG   = 3'd3;
  localparam logic [2:0] S_FY   = 3'd4;
  localparam logic [2:0] S_AR2  = 3'd5;
  localparam logic [2:0] S_WALK = 3'd6;
`ifdef NIGHT_FLASH_EN
  localparam logic [2:0] S_FLASH = 3'd7;
  localparam logic [1:0] L_DARK  = 2'b11;
`endif

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;

  // Terminal counts: "after N ticks" fires when timer == N-1 on a tick.
  localparam logic [CNT_W-1:0] T_SAT  = '1;
  localparam logic [CNT_W-1:0] T_HMIN = CNT_W'(HWY_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] T_FMIN = CNT_W'(FARM_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_FMAX = CNT_W'(FARM_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] T_WALK = CNT_W'(PED_WALK - 1);

  logic [2:0]       state;
  logic [2:0]       nxt;
  logic [CNT_W-1:0] timer;
  logic             sensor_q;
  logic             sensor_s;
  logic             ped_q;
  logic             ped_s;
  logic             ped_pending;
  logic             ped_ack_q;
  logic             walk_entry;
  logic [1:0]       hwy;
  logic [1:0]       farm;
`ifdef NIGHT_FLASH_EN
  logic             night_q;
  logic             night_s;
  logic             flash_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sensor_q <= 1'b0;
      sensor_s <= 1'b0;
      ped_q    <= 1'b0;
      ped_s    <= 1'b0;
    end else begin
      sensor_q <= ctl.sensor;
      sensor_s <= sensor_q;
      ped_q    <= ctl.ped_req;
      ped_s    <= ped_q;
    end
  end

`ifdef NIGHT_FLASH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      night_q <= 1'b0;
      night_s <= 1'b0;
    end else begin
      night_q <= ctl.night_mode;
      night_s <= night_q;
    end
  end
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_HG:
        if (ctl.tick) begin
          // timer may sit past min green while idle, so compare with >=
          if (timer >= T_HMIN && (sensor_s || ped_pending))
            nxt = S_HY;
`ifdef NIGHT_FLASH_EN
          if (night_s)
            nxt = S_FLASH;
`endif
        end
      S_HY:
        if (ctl.tick && timer == T_YEL)
          nxt = S_AR1;
      S_AR1:
        if (ctl.tick && timer == T_AR)
          nxt = ped_pending ? S_WALK : S_FG;
      S_FG:
        if (ctl.tick) begin
          if (timer >= T_FMIN && (!sensor_s || ped_pending))
            nxt = S_FY;
          else if (timer >= T_FMAX)
            nxt = S_FY;
        end
      S_FY:
        if (ctl.tick && timer == T_YEL)
          nxt = S_AR2;
      S_AR2:
        if (ctl.tick && timer == T_AR)
          nxt = ped_pending ? S_WALK : S_HG;
      S_WALK:
        if (ctl.tick && timer == T_WALK)
          nxt = sensor_s ? S_FG : S_HG;
`ifdef NIGHT_FLASH_EN
      S_FLASH:
        if (ctl.tick && !night_s)
          nxt = S_AR2;
`endif
      default:
        nxt = S_HG;
    endcase
  end

  assign walk_entry = (nxt == S_WALK) && (state != S_WALK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_HG;
      timer       <= '0;
      ped_pending <= 1'b0;
      ped_ack_q   <= 1'b0;
    end else begin
      state     <= nxt;
      ped_ack_q <= walk_entry;
      if (nxt != state)
        timer <= '0;
      else if (ctl.tick && timer != T_SAT)
        timer <= timer + CNT_W'(1);
      // clear on WALK entry beats a simultaneous set
      if (walk_entry)
        ped_pending <= 1'b0;
      else if (ped_s)
        ped_pending <= 1'b1;
    end
  end

`ifdef NIGHT_FLASH_EN
  // Held at 0 outside FLASH so the flash starts on YELLOW/RED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flash_q <= 1'b0;
    else if (state != S_FLASH)
      flash_q <= 1'b0;
    else if (ctl.tick)
      flash_q <= ~flash_q;
  end
`endif

  always_comb begin
    hwy  = L_RED;
    farm = L_RED;
    case (state)
      S_HG: hwy  = L_GRN;
      S_HY: hwy  = L_YEL;
      S_FG: farm = L_GRN;
      S_FY: farm = L_YEL;
`ifdef NIGHT_FLASH_EN
      S_FLASH: begin
        hwy  = flash_q ? L_DARK : L_YEL;
        farm = flash_q ? L_DARK : L_RED;
      end
`endif
      default: begin
        hwy  = L_RED;
        farm = L_RED;
      end
    endcase
  end

  assign ctl.highway_signal = hwy;
  assign ctl.farm_signal    = farm;
  assign ctl.phase          = state;
  assign ctl.ped_walk       = (state == S_WALK);
  assign ctl.ped_ack        = ped_ack_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: randomized scoreboard bench for traffic_phase_scheduler.
// A tick-count reference model predicts the lamps each cycle; a monitor compares.
module tb_traffic_phase_scheduler;

  localparam int HMIN  = 20;
  localparam int YEL   = 4;
  localparam int ARED  = 2;
  localparam int FMIN  = 10;
  localparam int FMAX  = 30;
  localparam int WALKT = 8;

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YLW = 2'b01;
  localparam logic [1:0] GRN = 2'b10;

  typedef struct packed {
    logic [2:0] phase;
    logic [1:0] hwy;
    logic [1:0] farm;
    logic       walk;
    logic       ack;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  traffic_phase_scheduler_if bus();

  traffic_phase_scheduler dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  obs_t sb[$];

  // reference model state: road phase, ticks spent in it, pending walk
  int m_phase = 0;
  int m_ticks = 0;
  bit m_pend = 0;
  bit s1 = 0, s2 = 0, p1 = 0, p2 = 0;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("FAIL %s t=%0t got ph=%0d h=%b f=%b w=%b a=%b need ph=%0d h=%b f=%b w=%b a=%b",
               name, $time, act.phase, act.hwy, act.farm, act.walk, act.ack,
               exp.phase, exp.hwy, exp.farm, exp.walk, exp.ack);
  endtask

  function automatic obs_t expect_of(int ph, bit ack);
    obs_t o;
    o.phase = 3'(ph);
    o.hwy   = (ph == 0) ? GRN : (ph == 1) ? YLW : RED;
    o.farm  = (ph == 3) ? GRN : (ph == 4) ? YLW : RED;
    o.walk  = (ph == 6);
    o.ack   = ack;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.phase = bus.phase;
    o.hwy   = bus.highway_signal;
    o.farm  = bus.farm_signal;
    o.walk  = bus.ped_walk;
    o.ack   = bus.ped_ack;
    return o;
  endfunction

  // Applies one clock edge to the model using the inputs held across it.
  task automatic model_edge();
    int done;
    int nxt;
    bit enter;
    enter = 0;
    if (!rst) begin
      m_phase = 0; m_ticks = 0; m_pend = 0;
      s1 = 0; s2 = 0; p1 = 0; p2 = 0;
    end else begin
      done = m_ticks + (bus.tick ? 1 : 0);
      nxt  = m_phase;
      if (bus.tick) begin
        case (m_phase)
          0: if (done >= HMIN && (s2 || m_pend)) nxt = 1;
          1: if (done == YEL) nxt = 2;
          2: if (done == ARED) nxt = m_pend ? 6 : 3;
          3: if ((done >= FMIN && (!s2 || m_pend)) || done >= FMAX) nxt = 4;
          4: if (done == YEL) nxt = 5;
          5: if (done == ARED) nxt = m_pend ? 6 : 0;
          6: if (done == WALKT) nxt = s2 ? 3 : 0;
          default: nxt = 0;
        endcase
      end
      enter   = (nxt == 6) && (m_phase != 6);
      m_pend  = (m_pend || p2) && !enter;
      m_ticks = (nxt != m_phase) ? 0 : done;
      m_phase = nxt;
      s2 = s1; s1 = bus.sensor;
      p2 = p1; p1 = bus.ped_req;
    end
    sb.push_back(expect_of(m_phase, enter));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cycle", observe(), e);
    end
  end

  initial begin
    int mode;
    int hold;
    bit found;
    bus.tick    = 1'b1;
    bus.sensor  = 1'b0;
    bus.ped_req = 1'b0;
`ifdef NIGHT_FLASH_EN
    bus.night_mode = 1'b0;
`endif
    rst = 1'b0;

    // reset held, then idle highway green
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 200; i++) step();

    // random traffic under three tick cadences
    hold = 0;
    for (int seg = 0; seg < 12; seg++) begin
      mode = seg % 3;
      for (int c = 0; c < 300; c++) begin
        case (mode)
          0: bus.tick = 1'b1;
          1: bus.tick = (c % 4 == 0);
          default: bus.tick = 1'($urandom_range(0, 1));
        endcase
        if ($urandom_range(0, 39) == 0)
          bus.sensor = ~bus.sensor;
        if (hold > 0) begin
          bus.ped_req = 1'b1;
          hold--;
        end else begin
          bus.ped_req = 1'b0;
          if ($urandom_range(0, 59) == 0)
            hold = $urandom_range(1, 3);
        end
        step();
      end
    end

    // drive into FG, latch a walk request, reset at FG timer 3
    bus.tick    = 1'b1;
    bus.sensor  = 1'b1;
    bus.ped_req = 1'b0;
    found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      bus.ped_req = (m_phase == 3 && m_ticks == 0);
      step();
      if (m_phase == 3 && m_ticks == 3 && m_pend)
        found = 1;
    end
    bus.ped_req = 1'b0;
    if (!found) begin
      checks++;
      $display("FAIL fg_reach got no FG timer=3 need FG timer=3 within 400 cycles");
    end else begin
      #5;
      rst = 1'b0;
      #1;
      check("async_reset", observe(), expect_of(0, 0));
      step();
      step();
      rst = 1'b1;
    end

    // no sensor, no request: a stale pending would leave HG
    bus.sensor = 1'b0;
    for (int i = 0; i < 120; i++) step();

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
